// File: rtl/timeout_counter_pkg.sv
// Shared types and constants for the event-count timeout generator.
package timeout_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timeout_counter_if.sv
// Control and status bundle between a strobe/control source and the timeout counter.
interface timeout_counter_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 4
);
    import timeout_counter_pkg::*;

    // No valid/ready pairing here: start, stop and increment are level-sampled
    // single-cycle strobes, acted on at every rising clk edge where they are high.
    logic              start;
    logic              stop;
    logic              increment;
    logic              mode;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  count;
    logic              timeout;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wraps;
    state_t            state;

    modport master (
        output start, stop, increment, mode, limit,
        input  count, timeout, busy, done, wraps, state
    );

    modport slave (
        input  start, stop, increment, mode, limit,
        output count, timeout, busy, done, wraps, state
    );

endinterface

// File: rtl/timeout_counter.sv
// Counts increment strobes and pulses timeout after a programmable limit,
// in one-shot or auto-reload mode, with a saturating tally of timeouts.
module timeout_counter
    import timeout_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    timeout_counter_if.slave   bus
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic              mode_q, mode_d;
    logic              timeout_q, timeout_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              terminal;

    // limit_q is never zero while in RUN, so limit_q-1 cannot underflow there.
    assign terminal = (count_q == limit_q - WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            timeout_q <= 1'b0;
            wraps_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            wraps_q   <= wraps_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        wraps_d   = wraps_q;

        if (bus.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (bus.start && (bus.limit != '0)) begin
            state_d = ST_RUN;
            limit_d = bus.limit;
            mode_d  = bus.mode;
            count_d = '0;
            wraps_d = '0;
        end else if ((state_q == ST_RUN) && bus.increment) begin
            if (terminal) begin
                count_d   = '0;
                timeout_d = 1'b1;
                if (wraps_q != '1)
                    wraps_d = wraps_q + WRAP_W'(1);
                if (mode_q == MODE_ONESHOT)
                    state_d = ST_DONE;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.wraps   = wraps_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_timeout_counter.sv
// Directed bench for timeout_counter with WIDTH=4, WRAP_W=2.
module tb_timeout_counter;
    import timeout_counter_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   tout_cnt;

    timeout_counter_if #(.WIDTH(4), .WRAP_W(2)) bus ();

    timeout_counter #(.WIDTH(4), .WRAP_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.timeout === 1'b1) tout_cnt++;
    endtask

    task automatic do_start(input logic [3:0] l, input logic m);
        bus.limit = l;
        bus.mode  = m;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic inc_n(input int n);
        bus.increment = 1'b1;
        repeat (n) step();
        bus.increment = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        tout_cnt = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.increment = 1'b0;
        bus.mode      = 1'b0;
        bus.limit     = 4'd0;
        #3;
        check("rst_count", 32'(bus.count), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_wraps", 32'(bus.wraps), 0);
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        #14;
        rst = 1'b1;
        step();

        // 1: one-shot, limit 10, increments separated by two idle cycles
        do_start(4'd10, MODE_ONESHOT);
        check("t1_busy0", 32'(bus.busy), 1);
        tout_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            inc_n(1);
            check("t1_count", 32'(bus.count), (k == 10) ? 0 : k);
            check("t1_timeout", 32'(bus.timeout), (k == 10) ? 1 : 0);
            step();
            check("t1_gap_timeout", 32'(bus.timeout), 0);
            step();
        end
        check("t1_pulses", 32'(tout_cnt), 1);
        check("t1_done", 32'(bus.done), 1);
        check("t1_busy", 32'(bus.busy), 0);
        check("t1_wraps", 32'(bus.wraps), 1);
        inc_n(1);
        check("t1_extra_count", 32'(bus.count), 0);
        check("t1_extra_timeout", 32'(bus.timeout), 0);

        // 2: auto-reload, limit 3, 15 back-to-back increments
        do_start(4'd3, MODE_RELOAD);
        check("t2_wraps_clr", 32'(bus.wraps), 0);
        tout_cnt = 0;
        bus.increment = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("t2_count", 32'(bus.count), i % 3);
            check("t2_timeout", 32'(bus.timeout), (i % 3 == 0) ? 1 : 0);
            check("t2_wraps", 32'(bus.wraps), (i / 3 > 3) ? 3 : i / 3);
            check("t2_busy", 32'(bus.busy), 1);
        end
        bus.increment = 1'b0;
        step();
        check("t2_pulses", 32'(tout_cnt), 5);
        check("t2_idle_timeout", 32'(bus.timeout), 0);

        // 3: auto-reload, limit 1, increment held four cycles
        do_start(4'd1, MODE_RELOAD);
        bus.increment = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_timeout", 32'(bus.timeout), 1);
            check("t3_count", 32'(bus.count), 0);
        end
        bus.increment = 1'b0;
        step();
        check("t3_release_timeout", 32'(bus.timeout), 0);
        check("t3_wraps", 32'(bus.wraps), 3);

        // 4: stop together with the terminal increment
        do_start(4'd9, MODE_RELOAD);
        inc_n(9 + 8);
        check("t4_count_pre", 32'(bus.count), 8);
        check("t4_wraps_pre", 32'(bus.wraps), 1);
        bus.stop = 1'b1;
        bus.increment = 1'b1;
        step();
        bus.stop = 1'b0;
        bus.increment = 1'b0;
        check("t4_timeout", 32'(bus.timeout), 0);
        check("t4_state", 32'(bus.state), 32'(ST_IDLE));
        check("t4_count", 32'(bus.count), 0);
        check("t4_wraps", 32'(bus.wraps), 1);
        step();
        check("t4_timeout_after", 32'(bus.timeout), 0);

        // 5: restart mid-run, then a start with limit 0
        do_start(4'd10, MODE_ONESHOT);
        inc_n(7);
        check("t5_count_pre", 32'(bus.count), 7);
        bus.increment = 1'b1;
        do_start(4'd2, MODE_ONESHOT);
        bus.increment = 1'b0;
        check("t5_count_restart", 32'(bus.count), 0);
        check("t5_wraps_restart", 32'(bus.wraps), 0);
        check("t5_busy_restart", 32'(bus.busy), 1);
        tout_cnt = 0;
        inc_n(1);
        check("t5_count1", 32'(bus.count), 1);
        inc_n(1);
        check("t5_timeout", 32'(bus.timeout), 1);
        check("t5_pulses", 32'(tout_cnt), 1);
        check("t5_done", 32'(bus.done), 1);
        do_start(4'd0, MODE_RELOAD);
        check("t5_zero_state", 32'(bus.state), 32'(ST_DONE));
        check("t5_zero_wraps", 32'(bus.wraps), 1);
        check("t5_zero_count", 32'(bus.count), 0);

        // 6: asynchronous reset between clock edges
        do_start(4'd6, MODE_RELOAD);
        inc_n(6 + 5);
        check("t6_count_pre", 32'(bus.count), 5);
        check("t6_wraps_pre", 32'(bus.wraps), 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_count", 32'(bus.count), 0);
        check("t6_async_busy", 32'(bus.busy), 0);
        check("t6_async_wraps", 32'(bus.wraps), 0);
        rst = 1'b1;
        inc_n(3);
        check("t6_post_count", 32'(bus.count), 0);
        check("t6_post_busy", 32'(bus.busy), 0);
        check("t6_post_timeout", 32'(bus.timeout), 0);
        do_start(4'd2, MODE_ONESHOT);
        inc_n(1);
        check("t6_restart_count", 32'(bus.count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
